// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin scheduler that shares one memory port (command / write-data /
//   read-data streams) between num_ports burst requesters. One requester is
//   granted at a time: its command is issued, then exactly len words are
//   steered between it and memory before arbitration runs again.
//
// Ports
//   reset, clk_mem              async active-low reset, rising-edge clock
//   req_valid/ready/rnw/addr/len  per-port burst request (ready is a one-cycle pulse)
//   wr_data/valid/ready         per-port write words, routed to mem_wr_*
//   rd_data/valid/ready         read words from mem_rd_*, data broadcast, valid one-hot
//   mem_cmd_data/valid/ready    {read_not_write, address, length}
//   mem_wr_*, mem_rd_*          memory data streams
//   grant                       index of current / last owner
//   busy                        high whenever not idle
//
// state | meaning
// IDLE  | scanning requests from rr pointer; zero-length requests acked here
// CMD   | presenting latched command, waiting for mem_cmd_ready
// WRITE | passing granted port's write words to memory
// READ  | passing memory read words to granted port
module mem_arbiter #(
   parameter int num_ports  = 4,
   parameter int mem_width  = 32,
   parameter int addr_width = 32,
   parameter int len_width  = 32,
   localparam int gw        = $clog2(num_ports),
   localparam int cmd_width = 1 + addr_width + len_width
) (
   input  logic                             reset,
   input  logic                             clk_mem,
   input  logic [num_ports-1:0]             req_valid,
   output logic [num_ports-1:0]             req_ready,
   input  logic [num_ports-1:0]             req_rnw,
   input  logic [num_ports*addr_width-1:0]  req_addr,
   input  logic [num_ports*len_width-1:0]   req_len,
   input  logic [num_ports*mem_width-1:0]   wr_data,
   input  logic [num_ports-1:0]             wr_valid,
   output logic [num_ports-1:0]             wr_ready,
   output logic [mem_width-1:0]             rd_data,
   output logic [num_ports-1:0]             rd_valid,
   input  logic [num_ports-1:0]             rd_ready,
   output logic [cmd_width-1:0]             mem_cmd_data,
   output logic                             mem_cmd_valid,
   input  logic                             mem_cmd_ready,
   output logic [mem_width-1:0]             mem_wr_data,
   output logic                             mem_wr_valid,
   input  logic                             mem_wr_ready,
   input  logic [mem_width-1:0]             mem_rd_data,
   input  logic                             mem_rd_valid,
   output logic                             mem_rd_ready,
   output logic [gw-1:0]                    grant,
   output logic                             busy
);

   typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

   state_t                state_q;
   logic [gw-1:0]         rr_q;
   logic [gw-1:0]         grant_q;
   logic                  rnw_q;
   logic [addr_width-1:0] addr_q;
   logic [len_width-1:0]  len_q;
   logic [len_width-1:0]  cnt_q;

   logic                  win_found;
   logic [gw-1:0]         win_idx;
   logic [len_width-1:0]  win_len;
   int                    cand;
   logic                  xfer;
   logic                  last_word;

   function automatic logic [gw-1:0] wrap_inc(input logic [gw-1:0] x);
      return (x == gw'(num_ports - 1)) ? '0 : x + gw'(1);
   endfunction

   // first requesting port at or after the rr pointer, wrapping
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int i = 0; i < num_ports; i++) begin
         cand = (int'(rr_q) + i) % num_ports;
         if (!win_found && req_valid[cand[gw-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[gw-1:0];
         end
      end
   end

   assign win_len   = req_len[win_idx*len_width +: len_width];
   assign last_word = (cnt_q == len_q - len_width'(1));

   always_comb begin
      xfer = 1'b0;
      if (state_q == WRITE)
         xfer = wr_valid[grant_q] && mem_wr_ready;
      else if (state_q == READ)
         xfer = mem_rd_valid && rd_ready[grant_q];
   end

   always_ff @(posedge clk_mem or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  grant_q <= win_idx;
                  rnw_q   <= req_rnw[win_idx];
                  addr_q  <= req_addr[win_idx*addr_width +: addr_width];
                  len_q   <= win_len;
                  if (win_len == '0)
                     rr_q <= wrap_inc(win_idx);
                  else
                     state_q <= CMD;
               end
            end
            CMD: begin
               if (mem_cmd_ready) begin
                  cnt_q   <= '0;
                  state_q <= rnw_q ? READ : WRITE;
               end
            end
            WRITE, READ: begin
               if (xfer) begin
                  cnt_q <= cnt_q + len_width'(1);
                  if (last_word) begin
                     state_q <= IDLE;
                     rr_q    <= wrap_inc(grant_q);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // data paths are zero-cycle pass-through; everything is gated by state
   always_comb begin
      req_ready    = '0;
      wr_ready     = '0;
      rd_valid     = '0;
      mem_wr_valid = 1'b0;
      mem_rd_ready = 1'b0;
      case (state_q)
         IDLE: begin
            // zero-length requests complete here; reset gating keeps this
            // quiet while the block is held in reset
            if (reset && win_found && (win_len == '0))
               req_ready[win_idx] = 1'b1;
         end
         CMD:   req_ready[grant_q] = mem_cmd_ready;
         WRITE: begin
            mem_wr_valid      = wr_valid[grant_q];
            wr_ready[grant_q] = mem_wr_ready;
         end
         READ: begin
            rd_valid[grant_q] = mem_rd_valid;
            mem_rd_ready      = rd_ready[grant_q];
         end
         default: ;
      endcase
   end

   assign mem_cmd_valid = (state_q == CMD);
   assign mem_cmd_data  = {rnw_q, addr_q, len_q};
   assign mem_wr_data   = wr_data[grant_q*mem_width +: mem_width];
   assign rd_data       = mem_rd_data;
   assign grant         = grant_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter: requester tasks drive per-port bursts,
//   a memory model answers commands/reads, and a monitor pops expected
//   commands and words as the DUT hands them over.
module tb_mem_arbiter;
   localparam int NP = 4;
   localparam int MW = 32;
   localparam int AW = 32;
   localparam int LW = 32;
   localparam int GW = 2;

   logic               reset;
   logic               clk_mem;
   logic [NP-1:0]      req_valid, req_ready, req_rnw;
   logic [NP*AW-1:0]   req_addr;
   logic [NP*LW-1:0]   req_len;
   logic [NP*MW-1:0]   wr_data;
   logic [NP-1:0]      wr_valid, wr_ready, rd_valid, rd_ready;
   logic [MW-1:0]      rd_data;
   logic [64:0]        mem_cmd_data;
   logic               mem_cmd_valid, mem_cmd_ready;
   logic [MW-1:0]      mem_wr_data;
   logic               mem_wr_valid, mem_wr_ready;
   logic [MW-1:0]      mem_rd_data;
   logic               mem_rd_valid, mem_rd_ready;
   logic [GW-1:0]      grant;
   logic               busy;

   logic               p_valid  [NP];
   logic               p_rnw    [NP];
   logic               p_wvalid [NP];
   logic               p_rready [NP];
   logic [AW-1:0]      p_addr   [NP];
   logic [LW-1:0]      p_len    [NP];
   logic [MW-1:0]      p_wdata  [NP];

   typedef struct {
      int          port;
      logic [64:0] cmd;
   } cmd_exp_t;

   typedef struct {
      int          port;
      logic [31:0] data;
   } word_exp_t;

   cmd_exp_t    exp_cmd_q [$];
   word_exp_t   exp_wr_q  [$];
   word_exp_t   exp_rd_q  [$];
   logic [31:0] mem_pend  [$];

   int n_checks, n_pass;
   int rdy_cnt [NP];
   int rd_cnt  [NP];
   int wr_cnt, cmd_cnt, cmd_wait, stall_left;
   bit wr_toggle;

   mem_arbiter dut (
      .reset         (reset),
      .clk_mem       (clk_mem),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rnw       (req_rnw),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .wr_data       (wr_data),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .mem_cmd_data  (mem_cmd_data),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_ready (mem_cmd_ready),
      .mem_wr_data   (mem_wr_data),
      .mem_wr_valid  (mem_wr_valid),
      .mem_wr_ready  (mem_wr_ready),
      .mem_rd_data   (mem_rd_data),
      .mem_rd_valid  (mem_rd_valid),
      .mem_rd_ready  (mem_rd_ready),
      .grant         (grant),
      .busy          (busy)
   );

   initial clk_mem = 1'b0;
   always #5 clk_mem = ~clk_mem;

   always_comb begin
      req_valid = '0;
      req_rnw   = '0;
      req_addr  = '0;
      req_len   = '0;
      wr_data   = '0;
      wr_valid  = '0;
      rd_ready  = '0;
      for (int i = 0; i < NP; i++) begin
         req_valid[i]          = p_valid[i];
         req_rnw[i]            = p_rnw[i];
         req_addr[i*AW +: AW]  = p_addr[i];
         req_len[i*LW +: LW]   = p_len[i];
         wr_data[i*MW +: MW]   = p_wdata[i];
         wr_valid[i]           = p_wvalid[i];
         rd_ready[i]           = p_rready[i];
      end
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] addr, input int k);
      return 32'h5A00_0000 + addr + k;
   endfunction

   task automatic expect_burst(input int p, input bit rnw, input logic [31:0] addr,
                               input logic [31:0] len, input logic [31:0] base);
      exp_cmd_q.push_back('{port: p, cmd: {rnw, addr, len}});
      for (int k = 0; k < int'(len); k++) begin
         if (rnw) exp_rd_q.push_back('{port: p, data: rd_word(addr, k)});
         else     exp_wr_q.push_back('{port: p, data: base + k});
      end
   endtask

   task automatic do_req(input int p, input bit rnw, input logic [31:0] addr,
                         input logic [31:0] len, input logic [31:0] base);
      int guard;
      int tgt;
      p_rnw[p]    = rnw;
      p_addr[p]   = addr;
      p_len[p]    = len;
      p_valid[p]  = 1'b1;
      p_rready[p] = rnw;
      tgt   = rd_cnt[p] + int'(len);
      guard = 0;
      do begin
         @(negedge clk_mem);
         guard++;
      end while (!req_ready[p] && guard < 400);
      if (!req_ready[p]) begin
         check($sformatf("req_timeout_p%0d", p), 0, 1);
         p_valid[p]  = 1'b0;
         p_rready[p] = 1'b0;
         return;
      end
      @(posedge clk_mem); #1;
      p_valid[p] = 1'b0;
      if (!rnw) begin
         for (int k = 0; k < int'(len); k++) begin
            p_wvalid[p] = 1'b1;
            p_wdata[p]  = base + k;
            guard = 0;
            do begin
               @(negedge clk_mem);
               guard++;
            end while (!wr_ready[p] && guard < 200);
            if (!wr_ready[p]) begin
               check($sformatf("wr_timeout_p%0d", p), 0, 1);
               break;
            end
            @(posedge clk_mem); #1;
         end
         p_wvalid[p] = 1'b0;
      end else begin
         guard = 0;
         while (rd_cnt[p] < tgt && guard < 200) begin
            @(posedge clk_mem);
            guard++;
         end
         if (rd_cnt[p] < tgt) check($sformatf("rd_timeout_p%0d", p), rd_cnt[p], tgt);
         #1;
         p_rready[p] = 1'b0;
      end
   endtask

   // monitor + memory model
   initial begin : mem_side
      logic [64:0] held;
      bit          hold_chk;
      bit          rd_fire;
      cmd_exp_t    ce;
      word_exp_t   we;
      hold_chk = 1'b0;
      forever begin
         @(negedge clk_mem);
         rd_fire = 1'b0;
         if (reset) begin
            if (req_ready != '0) begin
               check("req_ready_onehot", {95'd0, $onehot(req_ready)}, 1);
               for (int p = 0; p < NP; p++) if (req_ready[p] && req_valid[p]) rdy_cnt[p]++;
            end
            if (hold_chk) check("cmd_stable", {mem_cmd_valid, mem_cmd_data}, {1'b1, held});
            hold_chk = 1'b0;
            if (mem_cmd_valid) begin
               if (!mem_cmd_ready) begin
                  cmd_wait++;
                  held     = mem_cmd_data;
                  hold_chk = 1'b1;
                  if (stall_left > 0) stall_left--;
               end else begin
                  cmd_cnt++;
                  if (exp_cmd_q.size() == 0) check("cmd_unexpected", mem_cmd_data, 0);
                  else begin
                     ce = exp_cmd_q.pop_front();
                     check("cmd", mem_cmd_data, ce.cmd);
                     check("cmd_grant", grant, ce.port);
                  end
                  if (mem_cmd_data[64])
                     for (int k = 0; k < int'(mem_cmd_data[31:0]); k++)
                        mem_pend.push_back(rd_word(mem_cmd_data[63:32], k));
               end
            end
            if (mem_wr_valid && mem_wr_ready) begin
               wr_cnt++;
               if (exp_wr_q.size() == 0) check("wr_unexpected", mem_wr_data, 0);
               else begin
                  we = exp_wr_q.pop_front();
                  check("wr_data", mem_wr_data, we.data);
                  check("wr_grant", grant, we.port);
               end
            end
            if (rd_valid != '0) begin
               if (exp_rd_q.size() == 0) check("rd_unexpected", rd_valid, 0);
               else begin
                  check("rd_valid_port", rd_valid, 1 << exp_rd_q[0].port);
                  if ((rd_valid & rd_ready) != '0) begin
                     we = exp_rd_q.pop_front();
                     check("rd_data", rd_data, we.data);
                     rd_cnt[we.port]++;
                  end
               end
            end
            rd_fire = mem_rd_valid && mem_rd_ready;
         end
         @(posedge clk_mem); #1;
         if (!reset) mem_pend.delete();
         else if (rd_fire && mem_pend.size() > 0) void'(mem_pend.pop_front());
         mem_rd_valid  = (mem_pend.size() > 0);
         mem_rd_data   = (mem_pend.size() > 0) ? mem_pend[0] : 32'h0;
         mem_cmd_ready = (stall_left == 0);
         mem_wr_ready  = wr_toggle ? ~mem_wr_ready : 1'b1;
      end
   end

   initial begin : main
      int c0, w0, r0, guard;
      n_checks = 0; n_pass = 0;
      wr_cnt = 0; cmd_cnt = 0; cmd_wait = 0; stall_left = 0; wr_toggle = 1'b0;
      for (int i = 0; i < NP; i++) begin
         p_valid[i] = 1'b0; p_rnw[i] = 1'b0; p_wvalid[i] = 1'b0; p_rready[i] = 1'b0;
         p_addr[i] = '0; p_len[i] = '0; p_wdata[i] = '0;
         rdy_cnt[i] = 0; rd_cnt[i] = 0;
      end
      mem_cmd_ready = 1'b0; mem_wr_ready = 1'b1; mem_rd_valid = 1'b0; mem_rd_data = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk_mem);
      #1;
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_cmd_valid", mem_cmd_valid, 0);
      check("rst_cmd_data", mem_cmd_data, 0);
      check("rst_hs_outs", {req_ready, wr_ready, rd_valid, mem_wr_valid, mem_rd_ready}, 0);
      reset = 1'b1;
      @(posedge clk_mem); #1;

      // single write burst on port 0
      expect_burst(0, 0, 32'h100, 4, 32'hA0);
      do_req(0, 0, 32'h100, 4, 32'hA0);
      check("t1_busy_low", busy, 0);
      check("t1_req_ready_pulses", rdy_cnt[0], 1);
      check("t1_words", wr_cnt, 4);
      check("t1_cmds", cmd_cnt, 1);

      // command stall + 50% write backpressure on port 3
      stall_left = 5; wr_toggle = 1'b1; cmd_wait = 0; wr_cnt = 0;
      @(posedge clk_mem); #1;
      expect_burst(3, 0, 32'h200, 6, 32'hB0);
      do_req(3, 0, 32'h200, 6, 32'hB0);
      check("t2_cmd_wait", cmd_wait, 5);
      check("t2_words", wr_cnt, 6);
      wr_toggle = 1'b0;
      @(posedge clk_mem); #1;

      // all ports read len 2 concurrently
      for (int p = 0; p < NP; p++) expect_burst(p, 1, 32'h1000 + 32'(p) * 32'h10, 2, 0);
      fork
         do_req(0, 1, 32'h1000, 2, 0);
         do_req(1, 1, 32'h1010, 2, 0);
         do_req(2, 1, 32'h1020, 2, 0);
         do_req(3, 1, 32'h1030, 2, 0);
      join
      for (int p = 0; p < NP; p++) check($sformatf("t3_rd_words_p%0d", p), rd_cnt[p], 2);
      check("t3_rd_q_empty", exp_rd_q.size(), 0);

      // zero-length request on port 2, then port 3
      c0 = cmd_cnt; w0 = cmd_wait; r0 = rdy_cnt[2];
      do_req(2, 0, 32'h0, 0, 0);
      check("t4_zero_ack", rdy_cnt[2], r0 + 1);
      check("t4_no_cmd", cmd_cnt + cmd_wait, c0 + w0);
      check("t4_busy_low", busy, 0);
      expect_burst(3, 0, 32'h300, 1, 32'hC0);
      do_req(3, 0, 32'h300, 1, 32'hC0);
      check("t4_p3_cmd", cmd_cnt, c0 + 1);

      // port 1 keeps requesting, port 3 requests once: order 1,3,1,1
      expect_burst(1, 0, 32'h400, 2, 32'hD0);
      expect_burst(3, 0, 32'h430, 2, 32'h30);
      expect_burst(1, 0, 32'h410, 2, 32'hE0);
      expect_burst(1, 0, 32'h420, 2, 32'hF0);
      fork
         begin
            do_req(1, 0, 32'h400, 2, 32'hD0);
            do_req(1, 0, 32'h410, 2, 32'hE0);
            do_req(1, 0, 32'h420, 2, 32'hF0);
         end
         begin
            repeat (2) @(posedge clk_mem);
            #1;
            do_req(3, 0, 32'h430, 2, 32'h30);
         end
      join
      check("t5_cmd_q_empty", exp_cmd_q.size(), 0);

      // reset in the middle of an 8-word write on port 0
      expect_burst(0, 0, 32'h500, 8, 32'h80);
      p_rnw[0] = 1'b0; p_addr[0] = 32'h500; p_len[0] = 8; p_valid[0] = 1'b1;
      guard = 0;
      do begin @(negedge clk_mem); guard++; end while (!req_ready[0] && guard < 100);
      check("t6_req_ack", req_ready[0], 1);
      @(posedge clk_mem); #1;
      p_valid[0] = 1'b0; p_wvalid[0] = 1'b1; p_wdata[0] = 32'h80;
      for (int k = 0; k < 2; k++) begin
         guard = 0;
         do begin @(negedge clk_mem); guard++; end while (!wr_ready[0] && guard < 100);
         @(posedge clk_mem); #1;
         p_wdata[0] = p_wdata[0] + 1;
      end
      #2 reset = 1'b0;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_grant", grant, 0);
      check("t6_rst_outs", {mem_cmd_valid, mem_wr_valid, mem_rd_ready, req_ready, wr_ready, rd_valid}, 0);
      exp_wr_q.delete();
      @(posedge clk_mem); #3;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk_mem);
         check("t6_no_forward", {mem_wr_valid, busy}, 0);
      end
      @(posedge clk_mem); #1;
      p_wvalid[0] = 1'b0;
      expect_burst(0, 0, 32'h600, 2, 32'h90);
      expect_burst(2, 0, 32'h620, 1, 32'h70);
      fork
         do_req(0, 0, 32'h600, 2, 32'h90);
         do_req(2, 0, 32'h620, 1, 32'h70);
      join

      repeat (2) @(posedge clk_mem);
      #1;
      check("end_cmd_q_empty", exp_cmd_q.size(), 0);
      check("end_wr_q_empty", exp_wr_q.size(), 0);
      check("end_rd_q_empty", exp_rd_q.size(), 0);
      check("end_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin scheduler sharing the single memory port (mem_cmd / mem_write / mem_read FIFO triple, clk_mem domain) between num_ports burst requesters, e.g. per-slot DAC/ADC audio buffers.
- Grants one requester at a time, issues its MemoryCommand, then steers exactly length write or read words between that requester and memory before re-arbitrating.

Parameters:
- num_ports, 4, number of requesters (2..8)
- mem_width, 32, data word width
- addr_width, 32, MemoryCommand address field width
- len_width, 32, MemoryCommand length field width (cmd width = 1+addr_width+len_width = 65)

Ports:
- reset  in  1  asynchronous, active-low reset
- clk_mem  in  1  memory-side clock, all logic rising-edge
- req_valid  in  num_ports  request pending per port
- req_ready  out  num_ports  one-hot pulse: request accepted/issued
- req_rnw  in  num_ports  1=read, 0=write per port
- req_addr  in  num_ports*addr_width  word address per port
- req_len  in  num_ports*len_width  burst length in words per port
- wr_data  in  num_ports*mem_width  write data per port
- wr_valid  in  num_ports  write word valid
- wr_ready  out  num_ports  write word accepted (granted port only)
- rd_data  out  mem_width  read data, broadcast to all ports
- rd_valid  out  num_ports  one-hot read word valid (granted port only)
- rd_ready  in  num_ports  read word accepted
- mem_cmd_data  out  65  {read_not_write, address, length}
- mem_cmd_valid  out  1
- mem_cmd_ready  in  1
- mem_wr_data  out  mem_width; mem_wr_valid out 1; mem_wr_ready in 1
- mem_rd_data  in  mem_width; mem_rd_valid in 1; mem_rd_ready out 1
- grant  out  $clog2(num_ports)  index of current/last owner
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, rr pointer=0, grant=0, word counter=0, latched command cleared; all valid/ready outputs 0; busy=0. Reset mid-burst abandons the burst; no further words forwarded.
- Handshake rule everywhere: transfer when valid && ready on the same rising edge; valid never depends on ready.
- IDLE: scan ports starting at rr pointer, wrapping modulo num_ports; first port with req_valid=1 wins. Latch rnw/addr/len, set grant. If len==0: pulse req_ready[grant] one cycle, no memory command, stay IDLE, rr=grant+1. Else go CMD next cycle. No request: stay IDLE.
- CMD: mem_cmd_valid=1 with latched fields; on mem_cmd_ready: pulse req_ready[grant] in that cycle, counter=0, go WRITE (rnw=0) or READ (rnw=1).
- WRITE: combinational pass-through: mem_wr_data=wr_data[grant], mem_wr_valid=wr_valid[grant], wr_ready[grant]=mem_wr_ready; other wr_ready=0. Counter increments per transfer; on transfer with counter==len-1 go IDLE, rr=grant+1.
- READ: rd_data=mem_rd_data, rd_valid[grant]=mem_rd_valid, mem_rd_ready=rd_ready[grant]; other rd_valid=0. Same counting/exit as WRITE. Read data outside READ: mem_rd_ready=0 (stall).
- Latency: request seen in IDLE -> mem_cmd_valid next cycle; data paths zero-cycle. Minimum 2 cycles between bursts (CMD->…->IDLE->CMD).
- Fairness: after a port is served, it has lowest priority; with all ports requesting, grant order is 0,1,2,3,0...
- Requests changing while not in IDLE are ignored; latched fields stable through the burst.
- Counter is len_width bits; len=2^len_width-1 supported without wrap error.

Test Plan:
- Single port 0 write, addr 0x100, len 4, words A0..A3 -> one mem_cmd {0,0x100,4}; mem_write sees A0..A3; req_ready[0] one pulse; busy falls after 4th word.
- Ports 0..3 all request read len 2 concurrently -> grants 0,1,2,3 in order; rd_valid one-hot matches grant; each port receives its 2 words only.
- Backpressure: mem_cmd_ready low 5 cycles, mem_wr_ready toggling 50% -> command held stable, no words lost/duplicated, count exact.
- len=0 request on port 2 -> req_ready[2] pulse, no mem_cmd_valid, next request on port 3 served.
- Reset asserted mid write burst (word 2 of 8) -> all outputs 0 immediately; after release, port 0 request served first with fresh command.
- Port 1 continuously requesting, port 3 requests once -> port 3 granted at most after one port 1 burst.
